// File: rtl/mod_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mod_pkg
// Brief   : Field constants and width helpers for q = 2^W - C arithmetic.
// Revision: 1.0
// ============================================================================
package mod_pkg;

    localparam int W_DEF = 255;
    localparam int C_DEF = 19;
    localparam int MAX_W = 1024;

    localparam logic [W_DEF-1:0] CONST_Q = {W_DEF{1'b1}} - W_DEF'(C_DEF - 1);

    function automatic logic [MAX_W-1:0] q_of(input int w, input int c);
        logic [MAX_W-1:0] q;
        q    = '0;
        q[w] = 1'b1;
        return q - MAX_W'(c);
    endfunction

    // T1 < (C+1) * 2^W, so it needs clog2(C+1) bits above the field width
    function automatic int fold_w(input int w, input int c);
        return w + $clog2(c + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_mul_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : mod_mul_pipe_if
// Brief   : Request/response handshake bundle for the modular multiplier.
// Revision: 1.0
// ============================================================================
interface mod_mul_pipe_if
    import mod_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     mul;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, x, y, req_tag, rsp_ready,
        input  req_ready, rsp_valid, mul, rsp_tag
    );

    modport slave (
        input  req_valid, x, y, req_tag, rsp_ready,
        output req_ready, rsp_valid, mul, rsp_tag
    );
endinterface
`default_nettype wire

// File: rtl/mod_fold.sv
`default_nettype none
// ============================================================================
// Module  : mod_fold
// Brief   : One reduction fold: C * in[IN_W-1:W] + in[W-1:0], since 2^W = C mod q.
// Revision: 1.0
// ============================================================================
module mod_fold
    import mod_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int C     = C_DEF,
    parameter int IN_W  = 2 * W_DEF,
    parameter int OUT_W = fold_w(W_DEF, C_DEF)
) (
    input  wire logic [IN_W-1:0]  in_data,
    output logic      [OUT_W-1:0] out_data
);
    logic [OUT_W-1:0] w_hi;
    logic [OUT_W-1:0] w_lo;

    // OUT_W is sized by the caller so the exact sum always fits
    assign w_hi     = OUT_W'(in_data[IN_W-1:W]);
    assign w_lo     = OUT_W'(in_data[W-1:0]);
    assign out_data = OUT_W'(C) * w_hi + w_lo;

endmodule
`default_nettype wire

// File: rtl/mod_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module  : mod_mul_pipe
// Brief   : Pipelined, back-pressurable (x*y) mod (2^W - C) with tag pass-through.
// Revision: 1.0
// ============================================================================
module mod_mul_pipe
    import mod_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int C      = C_DEF,
    parameter int TAG_W  = 4,
    parameter int STAGES = 2
) (
    input wire logic      i_clk,
    input wire logic      i_rst,
    mod_mul_pipe_if.slave bus
);
    localparam int                PW     = 2 * W;
    localparam int                FW     = fold_w(W, C);
    localparam logic [MAX_W-1:0]  Q_FULL = q_of(W, C);
    localparam logic [W:0]        Q      = Q_FULL[W:0];

    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("mod_mul_pipe: STAGES must be in 2..4");
        end
        if (C < 1 || $clog2(C + 1) > W / 2) begin : g_bad_c
            $error("mod_mul_pipe: C must satisfy 1 <= C < 2^(W/2)");
        end
    endgenerate

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] w_load;
    logic              w_accept;
    logic [TAG_W-1:0]  r_tag [STAGES];

    // A stage loads when empty or when its successor is vacating
    always_comb begin
        w_load             = '0;
        w_load[STAGES-1]   = !r_v[STAGES-1] || bus.rsp_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_load[k] = !r_v[k] || w_load[k+1];
        end
    end

    assign bus.req_ready = w_load[0];
    assign w_accept      = bus.req_valid && w_load[0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v <= '0;
        end else begin
            if (w_load[0]) begin
                r_v[0] <= w_accept;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_v[k] <= r_v[k-1];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_load[0]) begin
            r_tag[0] <= bus.req_tag;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (w_load[k]) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    logic [PW-1:0] r_p;
    logic [FW-1:0] w_t1;
    logic [FW-1:0] w_t1_q;
    logic [W:0]    w_t2;
    logic [W:0]    w_t2_q;
    logic [W-1:0]  w_diff;
    logic [W-1:0]  w_r;
    logic [W-1:0]  r_mul;

    always_ff @(posedge i_clk) begin
        if (w_load[0]) begin
            r_p <= PW'(bus.x) * PW'(bus.y);
        end
    end

    mod_fold #(.W(W), .C(C), .IN_W(PW), .OUT_W(FW)) u_fold1 (
        .in_data  (r_p),
        .out_data (w_t1)
    );

    generate
        if (STAGES >= 3) begin : g_t1_reg
            logic [FW-1:0] r_t1;
            always_ff @(posedge i_clk) begin
                if (w_load[1]) begin
                    r_t1 <= w_t1;
                end
            end
            assign w_t1_q = r_t1;
        end else begin : g_t1_comb
            assign w_t1_q = w_t1;
        end
    endgenerate

    mod_fold #(.W(W), .C(C), .IN_W(FW), .OUT_W(W + 1)) u_fold2 (
        .in_data  (w_t1_q),
        .out_data (w_t2)
    );

    generate
        if (STAGES == 4) begin : g_t2_reg
            logic [W:0] r_t2;
            always_ff @(posedge i_clk) begin
                if (w_load[2]) begin
                    r_t2 <= w_t2;
                end
            end
            assign w_t2_q = r_t2;
        end else begin : g_t2_comb
            assign w_t2_q = w_t2;
        end
    endgenerate

    // T2 < 2q, so one conditional subtract fully reduces; the low W bits of the
    // difference are exact because T2 - q < 2^W whenever T2 >= q
    assign w_diff = w_t2_q[W-1:0] - Q[W-1:0];
    assign w_r    = (w_t2_q >= Q) ? w_diff : w_t2_q[W-1:0];

    always_ff @(posedge i_clk) begin
        if (w_load[STAGES-1]) begin
            r_mul <= w_r;
        end
    end

    assign bus.rsp_valid = r_v[STAGES-1];
    assign bus.mul       = r_v[STAGES-1] ? r_mul : '0;
    assign bus.rsp_tag   = r_v[STAGES-1] ? r_tag[STAGES-1] : '0;

endmodule
`default_nettype wire
